// File: rtl/adsr_env.sv
// rtl/adsr_env.sv - ADSR envelope controller producing a 16-bit gain word for the Amp stage
module adsr_env #(
    parameter int CLKSPEED = 50_000_000,
    parameter int TICK_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [15:0] attack_step,
    input  logic [15:0] decay_step,
    input  logic [15:0] sustain_level,
    input  logic [15:0] release_step,
    output logic [15:0] amp,
    output logic [2:0]  state,
    output logic        active
);

    localparam bit PARAM_OK = (CLKSPEED > 0) && (TICK_DIV >= 2) && (TICK_DIV <= 65536);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);

    // Elaboration-time guard on the parameter ranges.
    if (!PARAM_OK) begin : g_param_check
        $error("adsr_env: TICK_DIV must be 2..65536 and CLKSPEED positive");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } env_state_t;

    env_state_t    state_r;
    env_state_t    state_n;
    logic [15:0]   amp_r;
    logic [15:0]   amp_n;
    logic [CW-1:0] tcnt;
    logic          tick;
    logic          gate_q;
    logic          rise;
    logic          fall;
    logic [16:0]   attack_sum;
    logic [16:0]   decay_thr;

    assign tick = (tcnt == TMAX);
    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    assign attack_sum = {1'b0, amp_r} + {1'b0, attack_step};
    assign decay_thr  = {1'b0, sustain_level} + {1'b0, decay_step};

    // Free-running tick prescaler, independent of the gate.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Gate history for edge detection; a key already held through reset
    // is not treated as a fresh press, so gate_q follows gate during reset.
    always_ff @(posedge clk) begin
        gate_q <= gate;
    end

    // State, gain and activity registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            amp_r   <= 16'h0000;
            active  <= 1'b0;
        end else begin
            state_r <= state_n;
            amp_r   <= amp_n;
            active  <= (state_n != S_IDLE);
        end
    end

    // Next-state and next-gain: gate edges take priority over tick arithmetic.
    always_comb begin
        state_n = state_r;
        amp_n   = amp_r;
        if (rise) begin
            state_n = S_ATTACK;
        end else if (fall && (state_r == S_ATTACK || state_r == S_DECAY ||
                              state_r == S_SUSTAIN)) begin
            state_n = S_RELEASE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    amp_n = 16'h0000;
                end
                S_ATTACK: begin
                    if (tick) begin
                        if (attack_sum >= 17'h0FFFF) begin
                            amp_n   = 16'hFFFF;
                            state_n = S_DECAY;
                        end else begin
                            amp_n = attack_sum[15:0];
                        end
                    end
                end
                S_DECAY: begin
                    if (tick) begin
                        if ({1'b0, amp_r} < decay_thr) begin
                            amp_n   = sustain_level;
                            state_n = S_SUSTAIN;
                        end else begin
                            amp_n = amp_r - decay_step;
                        end
                    end
                end
                S_SUSTAIN: begin
                    amp_n = sustain_level;
                end
                S_RELEASE: begin
                    if (tick) begin
                        if (amp_r <= release_step) begin
                            amp_n   = 16'h0000;
                            state_n = S_IDLE;
                        end else begin
                            amp_n = amp_r - release_step;
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    amp_n   = 16'h0000;
                end
            endcase
        end
    end

    assign amp   = amp_r;
    assign state = state_r;

endmodule

// File: tb/tb_adsr_env.sv
// tb/tb_adsr_env.sv - directed self-checking bench for adsr_env
module tb_adsr_env;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [15:0] amp;
    logic [2:0]  state;
    logic        active;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_cnt = 0;

    adsr_env #(.CLKSPEED(50_000_000), .TICK_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .sustain_level(sustain_level),
        .release_step (release_step),
        .amp          (amp),
        .state        (state),
        .active       (active)
    );

    always #5 clk = ~clk;

    // Reference prescaler: a tick is applied on the edge where tb_cnt is 3.
    always @(posedge clk) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_env(input string tag, input logic [15:0] e_amp, input logic [2:0] e_state);
        check({tag, ".amp"}, {16'h0, amp}, {16'h0, e_amp});
        check({tag, ".state"}, {29'h0, state}, {29'h0, e_state});
        check({tag, ".active"}, {31'h0, active}, {31'h0, (e_state != 3'd0)});
    endtask

    // From a negedge, advance to the negedge just after the next tick edge.
    task automatic wait_tick;
        while (tb_cnt != 3) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        gate = 1'b1;
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        sustain_level = 16'hC000;
        release_step  = 16'h2000;

        // Reset with gate held high
        cyc(2);
        check_env("reset", 16'h0000, 3'd0);
        rst = 1'b0;
        cyc(6);
        check_env("held_gate_no_rise", 16'h0000, 3'd0);

        // Fresh key press
        gate = 1'b0;
        cyc(1);
        gate = 1'b1;
        cyc(1);
        check_env("rise", 16'h0000, 3'd1);

        // Attack
        wait_tick; check_env("atk1", 16'h4000, 3'd1);
        wait_tick; check_env("atk2", 16'h8000, 3'd1);
        wait_tick; check_env("atk3", 16'hC000, 3'd1);
        wait_tick; check_env("atk_sat", 16'hFFFF, 3'd2);

        // Decay
        wait_tick; check_env("dec1", 16'hEFFF, 3'd2);
        wait_tick; check_env("dec2", 16'hDFFF, 3'd2);
        wait_tick; check_env("dec3", 16'hCFFF, 3'd2);
        wait_tick; check_env("dec_to_sus", 16'hC000, 3'd3);

        // Live sustain tracking, one edge, no tick wait
        sustain_level = 16'h4000;
        cyc(1); check_env("sus_live_lo", 16'h4000, 3'd3);
        sustain_level = 16'hC000;
        cyc(1); check_env("sus_live_hi", 16'hC000, 3'd3);

        // Key release and full release ramp
        gate = 1'b0;
        cyc(1); check_env("fall", 16'hC000, 3'd4);
        wait_tick; check_env("rel1", 16'hA000, 3'd4);
        wait_tick; check_env("rel2", 16'h8000, 3'd4);
        wait_tick; check_env("rel3", 16'h6000, 3'd4);
        wait_tick; check_env("rel4", 16'h4000, 3'd4);
        wait_tick; check_env("rel5", 16'h2000, 3'd4);
        wait_tick; check_env("rel_idle", 16'h0000, 3'd0);

        // Early release from attack at 0x8000
        gate = 1'b1;
        cyc(1); check_env("rise2", 16'h0000, 3'd1);
        wait_tick; check_env("atk2_1", 16'h4000, 3'd1);
        wait_tick; check_env("atk2_2", 16'h8000, 3'd1);
        gate = 1'b0;
        cyc(1); check_env("early_fall", 16'h8000, 3'd4);
        wait_tick; check_env("early_rel", 16'h6000, 3'd4);

        // Retrigger from release at 0x6000
        gate = 1'b1;
        cyc(1); check_env("retrig", 16'h6000, 3'd1);
        wait_tick; check_env("retrig_atk1", 16'hA000, 3'd1);
        wait_tick; check_env("retrig_atk2", 16'hE000, 3'd1);
        wait_tick; check_env("retrig_sat", 16'hFFFF, 3'd2);

        // sustain_level = 0xFFFF: decay exits on first tick
        sustain_level = 16'hFFFF;
        wait_tick; check_env("sus_max", 16'hFFFF, 3'd3);

        // release_step = 0xFFFF: release completes in one tick
        release_step = 16'hFFFF;
        gate = 1'b0;
        cyc(1); check_env("fall_max", 16'hFFFF, 3'd4);
        wait_tick; check_env("rel_max", 16'h0000, 3'd0);

        // attack_step = 0xF000: saturates without wrapping
        attack_step   = 16'hF000;
        sustain_level = 16'hC000;
        release_step  = 16'h2000;
        gate = 1'b1;
        cyc(1); check_env("rise3", 16'h0000, 3'd1);
        wait_tick; check_env("atkF_1", 16'hF000, 3'd1);
        wait_tick; check_env("atkF_sat", 16'hFFFF, 3'd2);

        // Mid-envelope reset aborts immediately
        wait_tick; check_env("pre_rst_dec", 16'hEFFF, 3'd2);
        rst = 1'b1;
        cyc(1); check_env("mid_reset", 16'h0000, 3'd0);
        rst = 1'b0;
        cyc(3); check_env("post_reset_held", 16'h0000, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
